// File: rtl/lock_sequencer.sv
// Keypad code-entry controller: collects BCD digits, checks them against a stored code,
// and sequences the unlocked, lockout and reprogramming periods on the tick_in timebase.
module lock_sequencer #(
  parameter int                      CODE_LEN      = 4,
  parameter int                      MAX_FAIL      = 3,
  parameter int                      UNLOCK_TICKS  = 8,
  parameter int                      LOCKOUT_TICKS = 16,
  parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE  = 16'h1234
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       key_enter,
  input  logic       key_clear,
  input  logic       prog_req,
  output logic       unlocked,
  output logic       locked_out,
  output logic       error_pulse,
  output logic [2:0] digit_count,
  output logic [2:0] state_out
);

  localparam int EW   = 4 * CODE_LEN;
  localparam int TMAX = (UNLOCK_TICKS > LOCKOUT_TICKS) ? UNLOCK_TICKS : LOCKOUT_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int CW   = $clog2(CODE_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_PROG    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t          r_state, w_nxt;
  logic [EW-1:0]   r_entry, w_entry, r_code, w_code, w_shift;
  logic [CW-1:0]   r_count, w_count;
  logic [TW-1:0]   r_timer, w_timer;
  logic [FW-1:0]   r_fail, w_fail, w_fail_inc;
  logic            r_err, w_err;
  logic            w_can_accept, w_match, w_tick_dec;

  always_comb begin
    w_nxt        = r_state;
    w_entry      = r_entry;
    w_count      = r_count;
    w_timer      = r_timer;
    w_fail       = r_fail;
    w_code       = r_code;
    w_err        = 1'b0;
    w_shift      = (r_entry << 4) | EW'(key_digit);
    w_can_accept = (r_count < CW'(CODE_LEN));
    w_match      = (r_count == CW'(CODE_LEN)) && (r_entry == r_code);
    w_fail_inc   = r_fail + FW'(1);
    w_tick_dec   = tick_in && (r_timer != '0);

    case (r_state)
      S_IDLE: begin
        if (!key_clear && !key_enter && key_valid) begin
          w_entry = w_shift;
          w_count = CW'(1);
          w_nxt   = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (key_clear) begin
          w_entry = '0;
          w_count = '0;
          w_nxt   = S_IDLE;
        end else if (key_enter) begin
          w_nxt = S_CHECK;
        end else if (key_valid && w_can_accept) begin
          w_entry = w_shift;
          w_count = r_count + CW'(1);
        end
      end
      S_CHECK: begin
        w_entry = '0;
        w_count = '0;
        if (w_match) begin
          w_fail  = '0;
          w_timer = TW'(UNLOCK_TICKS);
          w_nxt   = S_OPEN;
        end else begin
          w_err = 1'b1;
          if (w_fail_inc >= FW'(MAX_FAIL)) begin
            w_fail  = '0;
            w_timer = TW'(LOCKOUT_TICKS);
            w_nxt   = S_LOCKOUT;
          end else begin
            w_fail = w_fail_inc;
            w_nxt  = S_IDLE;
          end
        end
      end
      S_OPEN: begin
        // Reprogramming abandons whatever is left of the open period.
        if (prog_req) begin
          w_entry = '0;
          w_count = '0;
          w_timer = '0;
          w_nxt   = S_PROG;
        end else if (w_tick_dec) begin
          w_timer = r_timer - TW'(1);
          if (r_timer == TW'(1)) w_nxt = S_IDLE;
        end
      end
      S_PROG: begin
        if (key_clear) begin
          w_entry = '0;
          w_count = '0;
          w_nxt   = S_IDLE;
        end else if (key_enter) begin
          if (r_count == CW'(CODE_LEN)) w_code = r_entry;
          else                          w_err  = 1'b1;
          w_entry = '0;
          w_count = '0;
          w_nxt   = S_IDLE;
        end else if (key_valid && w_can_accept) begin
          w_entry = w_shift;
          w_count = r_count + CW'(1);
        end
      end
      S_LOCKOUT: begin
        if (w_tick_dec) begin
          w_timer = r_timer - TW'(1);
          if (r_timer == TW'(1)) w_nxt = S_IDLE;
        end
      end
      default: begin
        w_entry = '0;
        w_count = '0;
        w_nxt   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_entry <= '0;
      r_count <= '0;
      r_timer <= '0;
      r_fail  <= '0;
      r_code  <= DEFAULT_CODE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_entry <= w_entry;
      r_count <= w_count;
      r_timer <= w_timer;
      r_fail  <= w_fail;
      r_code  <= w_code;
      r_err   <= w_err;
    end
  end

  // digit_count is three bits wide; a count of 8 (CODE_LEN=8) shows as 0.
  assign unlocked    = (r_state == S_OPEN);
  assign locked_out  = (r_state == S_LOCKOUT);
  assign state_out   = r_state;
  assign error_pulse = r_err;
  assign digit_count = 3'(r_count);

endmodule

// File: tb/tb_lock_sequencer.sv
// Table-driven bench for lock_sequencer: per-cycle stimulus records with expected outputs,
// checked through a scoreboard queue, plus hand-written asynchronous reset sequences.
module tb_lock_sequencer;

  logic       clock_in = 1'b0;
  logic       reset = 1'b1;
  logic       tick_in = 1'b0, key_valid = 1'b0, key_enter = 1'b0, key_clear = 1'b0, prog_req = 1'b0;
  logic [3:0] key_digit = 4'h0;
  logic       unlocked, locked_out, error_pulse;
  logic [2:0] digit_count, state_out;

  lock_sequencer dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .tick_in    (tick_in),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .key_enter  (key_enter),
    .key_clear  (key_clear),
    .prog_req   (prog_req),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .error_pulse(error_pulse),
    .digit_count(digit_count),
    .state_out  (state_out)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    string      nm;
    logic       kv;
    logic [3:0] dg;
    logic       ke, kc, pr, tk;
    logic [8:0] ex;   // {unlocked, locked_out, error_pulse, digit_count, state_out}
  } vec_t;

  vec_t       vecs[$];
  logic [8:0] sb[$];
  int         n_vec  = 0;
  int         n_miss = 0;

  function automatic logic [8:0] eo(input logic unl, input logic lo, input logic er,
                                    input logic [2:0] cnt, input logic [2:0] st);
    return {unl, lo, er, cnt, st};
  endfunction

  task automatic add(input string nm, input logic kv, input logic [3:0] dg, input logic ke,
                     input logic kc, input logic pr, input logic tk, input logic [8:0] ex);
    vec_t v;
    v.nm = nm; v.kv = kv; v.dg = dg; v.ke = ke; v.kc = kc; v.pr = pr; v.tk = tk; v.ex = ex;
    vecs.push_back(v);
  endtask

  task automatic check_out(input string nm);
    logic [8:0] ex, got;
    got = {unlocked, locked_out, error_pulse, digit_count, state_out};
    n_vec++;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL %s: scoreboard empty, got %b", nm, got);
    end else begin
      ex = sb.pop_front();
      if (got !== ex) begin
        n_miss++;
        $display("FAIL %s @%0t: got unl/lo/err/cnt/st=%b required %b", nm, $time, got, ex);
      end
    end
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) begin
      key_valid = vecs[i].kv; key_digit = vecs[i].dg; key_enter = vecs[i].ke;
      key_clear = vecs[i].kc; prog_req = vecs[i].pr; tick_in = vecs[i].tk;
      sb.push_back(vecs[i].ex);
      @(posedge clock_in);
      #1;
      key_valid = 0; key_digit = 0; key_enter = 0; key_clear = 0; prog_req = 0; tick_in = 0;
      check_out(vecs[i].nm);
    end
    vecs.delete();
  endtask

  task automatic hw_reset(input string nm);
    #2 reset = 1'b1;
    #1;
    sb.push_back(9'b0);
    check_out(nm);
    @(posedge clock_in);
    #1 reset = 1'b0;
    sb.push_back(9'b0);
    check_out({nm, "_release"});
  endtask

  task automatic enter4(input logic [15:0] code, input logic [2:0] st);
    for (int i = 0; i < 4; i++)
      add("digit", 1, code[15-4*i -: 4], 0, 0, 0, 0, eo(0, 0, 0, 3'(i + 1), st));
  endtask

  task automatic ok_check(input logic tk);
    add("enter_ok", 0, 0, 1, 0, 0, 0, eo(0, 0, 0, 4, 2));
    add("check_pass", 0, 0, 0, 0, 0, tk, eo(1, 0, 0, 0, 3));
  endtask

  task automatic bad_check(input logic [2:0] cnt, input logic lock);
    add("enter_bad", 0, 0, 1, 0, 0, 0, eo(0, 0, 0, cnt, 2));
    add("check_fail", 0, 0, 0, 0, 0, 0, eo(0, lock, 1, 0, lock ? 3'd5 : 3'd0));
    add("err_drop", 0, 0, 0, 0, 0, 0, eo(0, lock, 0, 0, lock ? 3'd5 : 3'd0));
  endtask

  task automatic ticks(input int n, input logic lo);
    for (int i = 0; i < n; i++) begin
      if (i < n - 1) add(lo ? "lock_tick" : "open_tick", 0, 0, 0, 0, 0, 1,
                         eo(!lo, lo, 0, 0, lo ? 3'd5 : 3'd3));
      else           add("timer_expire", 0, 0, 0, 0, 0, 1, eo(0, 0, 0, 0, 0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clock_in);
    #1;
    sb.push_back(9'b0);
    check_out("reset_state");
    reset = 1'b0;

    // IDLE ignores enter/clear; clear and enter outrank a coincident digit
    add("idle_enter", 0, 0, 1, 0, 0, 0, eo(0, 0, 0, 0, 0));
    add("idle_clear", 0, 0, 0, 1, 0, 0, eo(0, 0, 0, 0, 0));
    add("idle_kv_kc", 1, 4'd1, 0, 1, 0, 0, eo(0, 0, 0, 0, 0));
    add("idle_kv_ke", 1, 4'd1, 1, 0, 0, 0, eo(0, 0, 0, 0, 0));
    // correct code; tick during CHECK not counted; keys ignored in OPEN
    enter4(16'h1234, 3'd1);
    ok_check(1);
    add("open_key", 1, 4'd5, 0, 0, 0, 0, eo(1, 0, 0, 0, 3));
    ticks(8, 0);
    // three failures -> lockout; keys and prog ignored for 16 ticks
    for (int k = 0; k < 3; k++) begin
      enter4(16'h1235, 3'd1);
      bad_check(4, k == 2);
    end
    add("lock_key", 1, 4'd1, 0, 0, 0, 0, eo(0, 1, 0, 0, 5));
    add("lock_enter", 0, 0, 1, 0, 0, 0, eo(0, 1, 0, 0, 5));
    add("lock_prog", 0, 0, 0, 0, 1, 0, eo(0, 1, 0, 0, 5));
    ticks(16, 1);
    enter4(16'h1234, 3'd1);
    ok_check(0);
    ticks(8, 0);
    // two failures then success clears the fail counter
    for (int k = 0; k < 2; k++) begin
      enter4(16'h1235, 3'd1);
      bad_check(4, 0);
    end
    enter4(16'h1234, 3'd1);
    ok_check(0);
    ticks(8, 0);
    for (int k = 0; k < 3; k++) begin
      enter4(16'h1235, 3'd1);
      bad_check(4, k == 2);
    end
    ticks(16, 1);
    run_vecs();

    // reprogramming: prog beats a coincident tick, new code replaces old
    enter4(16'h1234, 3'd1);
    ok_check(0);
    add("prog_over_tick", 0, 0, 0, 0, 1, 1, eo(0, 0, 0, 0, 4));
    enter4(16'h9876, 3'd4);
    add("prog_store", 0, 0, 1, 0, 0, 0, eo(0, 0, 0, 0, 0));
    enter4(16'h1234, 3'd1);
    bad_check(4, 0);
    enter4(16'h9876, 3'd1);
    ok_check(0);
    add("prog_req", 0, 0, 0, 0, 1, 0, eo(0, 0, 0, 0, 4));
    add("prog_digit", 1, 4'd5, 0, 0, 0, 0, eo(0, 0, 0, 1, 4));
    add("prog_short", 0, 0, 1, 0, 0, 0, eo(0, 0, 1, 0, 0));
    add("prog_err_drop", 0, 0, 0, 0, 0, 0, eo(0, 0, 0, 0, 0));
    enter4(16'h9876, 3'd1);
    ok_check(0);
    add("prog_req2", 0, 0, 0, 0, 1, 0, eo(0, 0, 0, 0, 4));
    add("prog_digit2", 1, 4'd1, 0, 0, 0, 0, eo(0, 0, 0, 1, 4));
    add("prog_clear", 0, 0, 0, 1, 0, 0, eo(0, 0, 0, 0, 0));
    run_vecs();
    hw_reset("reset_restores_code");
    enter4(16'h1234, 3'd1);
    ok_check(0);
    ticks(8, 0);

    // saturation at CODE_LEN; clear beats enter; entry holds first four digits
    for (int i = 1; i <= 6; i++)
      add("sat_digit", 1, 4'(i), 0, 0, 0, 0, eo(0, 0, 0, (i < 4) ? 3'(i) : 3'd4, 1));
    add("clear_over_enter", 0, 0, 1, 1, 0, 0, eo(0, 0, 0, 0, 0));
    add("no_check", 0, 0, 0, 0, 0, 0, eo(0, 0, 0, 0, 0));
    for (int i = 1; i <= 6; i++)
      add("sat_digit", 1, 4'(i), 0, 0, 0, 0, eo(0, 0, 0, (i < 4) ? 3'(i) : 3'd4, 1));
    ok_check(0);
    ticks(8, 0);
    add("entry_digit", 1, 4'd1, 0, 0, 0, 0, eo(0, 0, 0, 1, 1));
    add("entry_kv_kc", 1, 4'd2, 0, 1, 0, 0, eo(0, 0, 0, 0, 0));
    for (int i = 1; i <= 3; i++)
      add("short_digit", 1, 4'(i), 0, 0, 0, 0, eo(0, 0, 0, 3'(i), 1));
    add("entry_kv_ke", 1, 4'd4, 1, 0, 0, 0, eo(0, 0, 0, 3, 2));
    add("short_fail", 0, 0, 0, 0, 0, 0, eo(0, 0, 1, 0, 0));
    add("short_err_drop", 0, 0, 0, 0, 0, 0, eo(0, 0, 0, 0, 0));
    // fail count is now 1: two more failures reach lockout
    enter4(16'h1235, 3'd1);
    bad_check(4, 0);
    enter4(16'h1235, 3'd1);
    bad_check(4, 1);
    for (int i = 0; i < 3; i++) add("lock_tick", 0, 0, 0, 0, 0, 1, eo(0, 1, 0, 0, 5));
    run_vecs();
    hw_reset("reset_mid_lockout");
    add("digit", 1, 4'd1, 0, 0, 0, 0, eo(0, 0, 0, 1, 1));
    add("digit", 1, 4'd2, 0, 0, 0, 0, eo(0, 0, 0, 2, 1));
    run_vecs();
    hw_reset("reset_mid_entry");
    enter4(16'h1234, 3'd1);
    ok_check(0);
    ticks(8, 0);
    run_vecs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
